// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings and defaults for the vector fetch/dispatch controller.
package fetch_ctrl_pkg;

   // Controller FSM states; the encoding is visible on ctrl_state.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_THROTTLE = 2'd1,
      ST_HOLD     = 2'd2,
      ST_REPLAY   = 2'd3
   } ctrl_state_t;

   // Redirect source codes, listed from "no redirect" down to lowest priority.
   typedef enum logic [2:0] {
      SRC_NONE   = 3'd0,
      SRC_IRQ    = 3'd1,
      SRC_BR     = 3'd2,
      SRC_REPLAY = 3'd3,
      SRC_BPU    = 3'd4
   } redir_src_t;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_CNT_W    = 4;
   localparam int DEF_LIMIT_SV = 5;
   localparam int DEF_LIMIT_VV = 6;

endpackage

// File: rtl/redirect_prio_mux.sv
// Combinational four-way PC redirect selector: IRQ > BR > REPLAY > BPU.
module redirect_prio_mux
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              i_irq_req,
   input  logic [ADDR_W-1:0] i_irq_addr,
   input  logic              i_br_req,
   input  logic [ADDR_W-1:0] i_br_addr,
   input  logic              i_replay_req,
   input  logic [ADDR_W-1:0] i_replay_addr,
   input  logic              i_bpu_req,
   input  logic [ADDR_W-1:0] i_bpu_addr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic [2:0]        o_src
);

   // Pick the highest-priority active request; valid follows the source code.
   always_comb begin
      o_addr = '0;
      o_src  = SRC_NONE;
      if (i_irq_req) begin
         o_addr = i_irq_addr;
         o_src  = SRC_IRQ;
      end else if (i_br_req) begin
         o_addr = i_br_addr;
         o_src  = SRC_BR;
      end else if (i_replay_req) begin
         o_addr = i_replay_addr;
         o_src  = SRC_REPLAY;
      end else if (i_bpu_req) begin
         o_addr = i_bpu_addr;
         o_src  = SRC_BPU;
      end
      o_valid = (o_src != SRC_NONE);
   end

endmodule

// File: rtl/vec_fetch_dispatch_ctrl.sv
// Fetch throttle/replay controller for vector stalls plus redirect arbitration.
// Optional performance counters are built when VEC_FETCH_PERF_EN is defined.
module vec_fetch_dispatch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int LIMIT_SV = DEF_LIMIT_SV,
   parameter int LIMIT_VV = DEF_LIMIT_VV
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              Vector__Stall,
   input  logic [1:0]        Vector_release_counter,
   input  logic              sv_vv,
   input  logic              IF_ID_Freeze,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] pc_cur,
   input  logic              PC_Control__IRQ,
   input  logic [ADDR_W-1:0] ISR_ADDRESS,
   input  logic              Branch_Taken__EX_MEM,
   input  logic [ADDR_W-1:0] Branch_Target_Addr__EX_MEM,
   input  logic              BPU__Branch_Taken__IF_ID,
   input  logic [ADDR_W-1:0] BPU__Branch_Target_Addr__IF_ID,
   output logic              fetch_hold,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_addr,
   output logic [2:0]        redirect_src,
   output logic [CNT_W-1:0]  dispatch_count,
`ifdef VEC_FETCH_PERF_EN
   output logic [31:0]       perf_hold_cycles,
   output logic [31:0]       perf_replays,
`endif
   output logic [1:0]        ctrl_state
);

   localparam logic [CNT_W-1:0] LIM_SV_C = CNT_W'(LIMIT_SV);
   localparam logic [CNT_W-1:0] LIM_VV_C = CNT_W'(LIMIT_VV);

   ctrl_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [CNT_W-1:0]  r_limit, w_limit_nxt;
   logic [ADDR_W-1:0] r_replay_pc, w_replay_pc_nxt;
   logic [CNT_W-1:0]  w_count_inc;
   logic              w_flush;
   logic              w_release;
   logic              w_dispatch;
   logic              w_irq_req;
   logic              w_br_req;
   logic              w_replay_req;
   logic              w_bpu_req;

   assign w_flush    = PC_Control__IRQ | Branch_Taken__EX_MEM;
   assign w_release  = ~Vector__Stall | (Vector_release_counter != 2'b00);
   assign w_dispatch = fetch_valid & ~IF_ID_Freeze;
   assign w_count_inc = (r_count >= r_limit) ? r_limit : (r_count + CNT_W'(1));

   // State, counter, limit and replay PC registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_limit     <= LIM_VV_C;
         r_replay_pc <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_limit     <= w_limit_nxt;
         r_replay_pc <= w_replay_pc_nxt;
      end
   end

   // Next-state logic; a flush from IRQ or resolved branch overrides everything.
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_limit_nxt     = r_limit;
      w_replay_pc_nxt = r_replay_pc;
      if (w_flush) begin
         w_state_nxt = ST_IDLE;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_count_nxt = '0;
               if (Vector__Stall) begin
                  w_state_nxt = ST_THROTTLE;
                  w_limit_nxt = sv_vv ? LIM_SV_C : LIM_VV_C;
               end
            end
            ST_THROTTLE: begin
               if (w_release) begin
                  w_state_nxt = ST_IDLE;
                  w_count_nxt = '0;
               end else if (w_dispatch) begin
                  w_count_nxt = w_count_inc;
                  if (w_count_inc == r_limit) begin
                     w_state_nxt     = ST_HOLD;
                     w_replay_pc_nxt = pc_cur;
                  end
               end
            end
            ST_HOLD: begin
               if (w_release) begin
                  w_state_nxt = ST_REPLAY;
               end
            end
            ST_REPLAY: begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   // Requests are qualified by reset so every output reads 0 while reset is asserted.
   assign fetch_hold     = (r_state == ST_HOLD);
   assign w_irq_req      = PC_Control__IRQ & RST_N;
   assign w_br_req       = Branch_Taken__EX_MEM & RST_N;
   assign w_replay_req   = (r_state == ST_REPLAY) & RST_N;
   assign w_bpu_req      = BPU__Branch_Taken__IF_ID & ~fetch_hold & RST_N;
   assign dispatch_count = r_count;
   assign ctrl_state     = r_state;

   redirect_prio_mux #(
      .ADDR_W (ADDR_W)
   ) u_prio (
      .i_irq_req     (w_irq_req),
      .i_irq_addr    (ISR_ADDRESS),
      .i_br_req      (w_br_req),
      .i_br_addr     (Branch_Target_Addr__EX_MEM),
      .i_replay_req  (w_replay_req),
      .i_replay_addr (r_replay_pc),
      .i_bpu_req     (w_bpu_req),
      .i_bpu_addr    (BPU__Branch_Target_Addr__IF_ID),
      .o_valid       (redirect_valid),
      .o_addr        (redirect_addr),
      .o_src         (redirect_src)
   );

`ifdef VEC_FETCH_PERF_EN
   logic [31:0] r_perf_hold;
   logic [31:0] r_perf_rep;

   // Free-running (wrapping) counts of HOLD cycles and issued replays.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_perf_hold <= '0;
         r_perf_rep  <= '0;
      end else begin
         if (r_state == ST_HOLD) begin
            r_perf_hold <= r_perf_hold + 32'd1;
         end
         if (redirect_src == SRC_REPLAY) begin
            r_perf_rep <= r_perf_rep + 32'd1;
         end
      end
   end

   assign perf_hold_cycles = r_perf_hold;
   assign perf_replays     = r_perf_rep;
`endif

endmodule
